turn_signal_conditioner: RTL and testbench
==========================================

# turn_signal_conditioner

Input-conditioning stage that sits directly upstream of the tail-light sequencer FSM. It synchronizes and debounces the raw left, right and hazard switches and merges them into the sequencer's L/R request pair. It also generates a slow step tick from a prescaler. L/R are updated only on tick cycles, so the sequencer sees requests that stay constant for a full step interval.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: number of consecutive clocks a synchronized input must differ from its debounced value before the new value is accepted. Must be ≥1.
- TICK_DIV, default 8: prescaler period in clocks; one tick per period. Must be ≥2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- left_sw  input  1  raw left turn switch, asynchronous to clk
- right_sw  input  1  raw right turn switch, asynchronous to clk
- hazard_sw  input  1  raw hazard switch, asynchronous to clk
- L  output  1  registered left request to the sequencer
- R  output  1  registered right request to the sequencer
- tick  output  1  one-clock step pulse marking each L/R update

## Operation
- **Synchronizer**
  - Each raw switch passes through its own 2-flop synchronizer: s1 samples the raw input, s2 samples s1.
- **Debounce**, per input (db_left, db_right, db_hazard):
  - Each input has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == db: counter <= 0.
  - If s2 != db and counter == DEBOUNCE_CYCLES-1: db <= s2 and counter <= 0.
  - Otherwise, when s2 != db: counter <= counter+1.
  - A pulse shorter than DEBOUNCE_CYCLES sampled clocks is rejected.
  - Chatter that returns s2 to db restarts the count from 0.
- **Request merge** (combinational):
  - req_l = db_left | db_hazard.
  - req_r = db_right | db_hazard.
  - Left and right both debounced high is presented as both requests, identical to hazard.
- **Prescaler**
  - cnt counts 0..TICK_DIV-1 and wraps to 0.
  - On the edge where cnt == TICK_DIV-1: cnt <= 0, tick <= 1, L <= req_l, R <= req_r.
  - On all other edges: tick <= 0, and L/R hold their values.
- **Reset**
  - Async assertion forces every flop to 0: sync flops, db values, debounce counters, cnt, L, R, tick.
  - Reset mid-operation discards all partial debounce progress and restarts the prescaler phase.
- **Hold behaviour**
  - L/R never change on a non-tick edge, even if the debounced inputs change.
  - A request that asserts and deasserts between two ticks is never seen at L/R.

## Timing
- Reset values: L=0, R=0, tick=0.
- Tick cadence:
  - With reset released before clock edge 1, tick is high after edge TICK_DIV.
  - It then rises again every TICK_DIV edges and is high for exactly 1 cycle.
- Debounce latency:
  - Raw change sampled at edge k → s2 changes at edge k+1 → db changes at edge k+1+DEBOUNCE_CYCLES.
  - Input held for at least DEBOUNCE_CYCLES sampled edges: accepted.
  - Input held for fewer: rejected.
- L/R latency:
  - L/R follow db on the first tick edge strictly after the db change, where req is read as its pre-edge value.
  - Total latency from the raw change is 2+DEBOUNCE_CYCLES .. 1+DEBOUNCE_CYCLES+TICK_DIV clocks.
- Simultaneous events:
  - A db change on the same edge as a tick is not captured by that tick; it is captured by the next tick.
  - Independent inputs debounce independently and concurrently.
- The sequencer consumes L/R on its clk; L/R are glitch-free flop outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TICK_DIV=8.

- **Reset and cadence:** assert reset, release, run 40 clocks → L=R=0 throughout; tick high only after edges 8, 16, 24, 32, 40.
- **Glitch rejection:** left_sw high for 3 clocks, then low → db_left never changes; L stays 0 across the next 3 ticks.
- **Clean left:** left_sw high at edge 1 and held → db_left=1 after edge 6; L=1 after edge 8 coincident with tick; R=0.
- **Hazard/both merge:** hazard_sw held high → L=R=1 at the first tick after debounce. Separately, left_sw and right_sw raised together with hazard low → same result, L=R=1.
- **Release and chatter:**
  - From L=1, left_sw toggles low 2 clocks, high 1 clock, then low and held → counter restarts; db_left=0 only 5 clocks after the final fall; L=0 at the following tick.
  - Also verify L holds 1 through the non-tick cycles before that tick.
- **Reset mid-operation:** with L=R=1 and a debounce in progress, pulse reset for 1 cycle → all outputs 0 immediately. The next tick comes 8 edges after release, and inputs still held high reassert L/R at that tick only if held ≥4 sampled clocks.

Source files
------------

// File: rtl/turn_signal_conditioner.sv
// Conditions raw left/right/hazard switches into tick-aligned L/R requests for the
// tail-light sequencer: 2-flop sync, per-input debounce, merge, and step prescaler.
module turn_signal_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    input  logic hazard_sw,
    output logic L,
    output logic R,
    output logic tick
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW  = $clog2(TICK_DIV);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    // bit 0 = left, bit 1 = right, bit 2 = hazard
    logic [2:0] raw;
    logic [2:0] s1_q, s2_q;
    logic [2:0] db_q, db_d;
    logic       req_l, req_r;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       tick_q, tick_d;
    logic       l_q, l_d, r_q, r_d;

    assign raw = {hazard_sw, right_sw, left_sw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            db_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            db_q <= db_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [DBW-1:0] dcnt_q, dcnt_d;
        logic           db_nxt;

        // any sample that agrees with the debounced value restarts the count
        always_comb begin
            dcnt_d = dcnt_q;
            db_nxt = db_q[i];
            if (s2_q[i] == db_q[i]) begin
                dcnt_d = '0;
            end else if (dcnt_q == DB_LAST) begin
                db_nxt = s2_q[i];
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        assign db_d[i] = db_nxt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_d;
            end
        end
    end

    assign req_l = db_q[0] | db_q[2];
    assign req_r = db_q[1] | db_q[2];

    // L/R sample the pre-edge requests, so a db change on a tick edge waits a full step
    always_comb begin
        tick_d = (cnt_q == CNT_LAST);
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
        l_d    = tick_d ? req_l : l_q;
        r_d    = tick_d ? req_r : r_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            l_q    <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            l_q    <= l_d;
            r_q    <= r_d;
        end
    end

    assign L    = l_q;
    assign R    = r_q;
    assign tick = tick_q;
endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Directed and randomized bench for turn_signal_conditioner against a sample-history reference model.
module tb_turn_signal_conditioner;
    localparam int DB = 4;
    localparam int TD = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic left_sw = 1'b0;
    logic right_sw = 1'b0;
    logic hazard_sw = 1'b0;
    logic L, R, tick;

    int total = 0;
    int bad   = 0;

    turn_signal_conditioner #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset),
        .left_sw(left_sw), .right_sw(right_sw), .hazard_sw(hazard_sw),
        .L(L), .R(R), .tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset, raw samples per edge, and the pre-edge
    // synchronized value per edge. A debounced bit flips when the last DB pre-edge
    // synchronized samples all disagree with it.
    int         n;
    logic [2:0] smp[$];
    logic [2:0] hist[$];
    logic [2:0] mdb;
    logic       mL, mR, mtick;

    function automatic void model_clear();
        n = 0;
        smp.delete();
        hist.delete();
        mdb = 3'b000;
        mL = 1'b0;
        mR = 1'b0;
        mtick = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [2:0] s2p;
        logic rl, rr, all_diff;
        n++;
        s2p = (n >= 3) ? smp[n-3] : 3'b000;
        smp.push_back({hazard_sw, right_sw, left_sw});
        hist.push_back(s2p);
        rl = mdb[0] | mdb[2];
        rr = mdb[1] | mdb[2];
        mtick = ((n % TD) == 0);
        if (mtick) begin
            mL = rl;
            mR = rr;
        end
        if (hist.size() >= DB) begin
            for (int i = 0; i < 3; i++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DB; k++)
                    if (hist[hist.size()-k][i] == mdb[i]) all_diff = 1'b0;
                if (all_diff) mdb[i] = ~mdb[i];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t edge=%0d observed=%b expected=%b", tag, $time, n, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("L", L, mL);
        chk("R", R, mR);
        chk("tick", tick, mtick);
    endtask

    // Pulse reset across one clock edge; outputs must clear asynchronously.
    task automatic apply_reset();
        reset = 1'b1;
        #2;
        chk("rst_L", L, 1'b0);
        chk("rst_R", R, 1'b0);
        chk("rst_tick", tick, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_hold_tick", tick, 1'b0);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic set_sw(input logic l, input logic r, input logic h);
        left_sw = l;
        right_sw = r;
        hazard_sw = h;
    endtask

    initial begin
        model_clear();
        #1;
        apply_reset();

        // reset and cadence: 40 quiet clocks
        for (int e = 1; e <= 40; e++) begin
            cycle();
            chk("cadence_tick", tick, (e % 8) == 0);
        end

        // glitch rejection: 3-clock pulse never reaches L
        left_sw = 1'b1;
        repeat (3) cycle();
        left_sw = 1'b0;
        repeat (30) begin
            cycle();
            chk("glitch_L", L, 1'b0);
        end

        // clean left from a fresh phase
        apply_reset();
        left_sw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            cycle();
            chk("clean_L", L, e >= 8);
            chk("clean_R", R, 1'b0);
        end

        // release with chatter: 2 low, 1 high, then low held
        set_sw(1'b0, 1'b0, 1'b0);
        repeat (2) cycle();
        left_sw = 1'b1;
        cycle();
        left_sw = 1'b0;
        repeat (30) cycle();
        chk("chatter_L_final", L, 1'b0);

        // hazard alone, then left+right together
        hazard_sw = 1'b1;
        repeat (20) cycle();
        chk("hazard_L", L, 1'b1);
        chk("hazard_R", R, 1'b1);
        hazard_sw = 1'b0;
        repeat (30) cycle();
        set_sw(1'b1, 1'b1, 1'b0);
        repeat (20) cycle();
        chk("both_L", L, 1'b1);
        chk("both_R", R, 1'b1);

        // reset mid-operation with a hazard debounce in progress
        hazard_sw = 1'b1;
        repeat (2) cycle();
        apply_reset();
        for (int e = 1; e <= 16; e++) begin
            cycle();
            chk("post_rst_L", L, e >= 8);
        end
        set_sw(1'b0, 1'b0, 1'b0);
        repeat (30) cycle();

        // directed pulse lengths around the debounce boundary at varied phases
        for (int len = 3; len <= 5; len++) begin
            for (int ph = 0; ph < TD; ph++) begin
                right_sw = 1'b1;
                repeat (len) cycle();
                right_sw = 1'b0;
                repeat (12 + ph) cycle();
            end
        end

        // randomized switching with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) left_sw = ~left_sw;
            if ($urandom_range(0, 7) == 0) right_sw = ~right_sw;
            if ($urandom_range(0, 11) == 0) hazard_sw = ~hazard_sw;
            if ($urandom_range(0, 599) == 0) apply_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
